// File: rtl/game_pkg.sv
// Shared types and default tuning constants for the level referee.
package game_pkg;

  localparam int unsigned WRAP_POS     = 680;
  localparam int unsigned WIN_PASSES   = 8;
  localparam int unsigned LIVES        = 3;
  localparam int unsigned COOLDOWN_CYC = 30;
  localparam logic [15:0] TIME_LIMIT   = 16'd3000;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned TIME_W  = 16;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned PASS_W  = 4;
  localparam int unsigned CD_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    COOLDOWN,
    WON,
    LOST
  } state_e;

endpackage

// File: rtl/pass_detector.sv
// Flags the first cycle the obstacle reaches the wrap position; a held
// position counts once because the above-flag must clear before re-arming.
module pass_detector
  import game_pkg::*;
#(
  parameter int unsigned WRAP_POS = game_pkg::WRAP_POS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [POS_W-1:0] obj_position_counter,
  output logic             pass_c
);

  logic at_or_above_c;
  logic above;

  assign at_or_above_c = (obj_position_counter >= POS_W'(WRAP_POS));
  assign pass_c        = at_or_above_c & ~above;

  always_ff @(posedge clk) begin
    if (reset) above <= 1'b0;
    else       above <= at_or_above_c;
  end

endmodule

// File: rtl/level_referee.sv
// Level referee: tracks lives, obstacle passes, hit cooldown and time limit,
// and decides when the player has won or lost the level.
module level_referee
  import game_pkg::*;
#(
  parameter int unsigned WRAP_POS     = game_pkg::WRAP_POS,
  parameter int unsigned WIN_PASSES   = game_pkg::WIN_PASSES,
  parameter int unsigned LIVES        = game_pkg::LIVES,
  parameter int unsigned COOLDOWN_CYC = game_pkg::COOLDOWN_CYC,
  parameter logic [15:0] TIME_LIMIT   = game_pkg::TIME_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               menuScreen,
  input  logic               start,
  input  logic               collision,
  input  logic [POS_W-1:0]   obj_position_counter,
  input  logic [TIME_W-1:0]  game_time,
  output logic               playerWon,
  output logic               playerLost,
  output logic               reset_obj_count,
  output logic               levelDone,
  output logic [LIVES_W-1:0] lives_left,
  output logic [PASS_W-1:0]  passes
);

  state_e             state, state_n;
  logic [CD_W-1:0]    cd_cnt, cd_n;
  logic [LIVES_W-1:0] lives_n;
  logic [PASS_W-1:0]  passes_n;
  logic [PASS_W-1:0]  pass_inc;
  logic               rst_obj_n;
  logic               done_n;
  logic               pass_c;

  pass_detector #(.WRAP_POS(WRAP_POS)) u_pass_detector (
    .clk                  (clk),
    .reset                (reset),
    .obj_position_counter (obj_position_counter),
    .pass_c               (pass_c)
  );

  assign pass_inc = passes + PASS_W'(1);

  // Next-state, counters and pulse decisions; outputs are registered below.
  always_comb begin
    state_n   = state;
    cd_n      = cd_cnt;
    lives_n   = lives_left;
    passes_n  = passes;
    rst_obj_n = 1'b0;
    done_n    = 1'b0;

    if (menuScreen) begin
      state_n  = IDLE;
      cd_n     = '0;
      lives_n  = '0;
      passes_n = '0;
    end else begin
      case (state)
        IDLE, WON, LOST: begin
          if (start) begin
            state_n  = PLAY;
            cd_n     = '0;
            lives_n  = LIVES_W'(LIVES);
            passes_n = '0;
          end
        end
        PLAY: begin
          if (collision) begin
            if (lives_left > LIVES_W'(1)) begin
              state_n   = COOLDOWN;
              lives_n   = lives_left - LIVES_W'(1);
              cd_n      = CD_W'(COOLDOWN_CYC);
              rst_obj_n = 1'b1;
            end else begin
              state_n = LOST;
              lives_n = '0;
            end
          end else if (pass_c) begin
            if (passes < PASS_W'(WIN_PASSES)) passes_n = pass_inc;
            if (passes_n == PASS_W'(WIN_PASSES)) begin
              state_n = WON;
              done_n  = 1'b1;
            end
          end else if (game_time >= TIME_LIMIT) begin
            state_n = LOST;
          end
        end
        COOLDOWN: begin
          cd_n = cd_cnt - CD_W'(1);
          if (cd_cnt <= CD_W'(1)) begin
            cd_n    = '0;
            state_n = PLAY;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cd_cnt          <= '0;
      lives_left      <= '0;
      passes          <= '0;
      reset_obj_count <= 1'b0;
      levelDone       <= 1'b0;
      playerWon       <= 1'b0;
      playerLost      <= 1'b0;
    end else begin
      state           <= state_n;
      cd_cnt          <= cd_n;
      lives_left      <= lives_n;
      passes          <= passes_n;
      reset_obj_count <= rst_obj_n;
      levelDone       <= done_n;
      playerWon       <= (state_n == WON);
      playerLost      <= (state_n == LOST);
    end
  end

endmodule

// File: tb/tb_level_referee.sv
// Scoreboard bench for level_referee: expectations queued with each stimulus
// cycle and compared just after the following clock edge.
module tb_level_referee;

  logic       clk = 1'b0;
  logic       reset;
  logic       menuScreen;
  logic       start;
  logic       collision;
  logic [9:0] obj_position_counter;
  logic [15:0] game_time;
  logic       playerWon;
  logic       playerLost;
  logic       reset_obj_count;
  logic       levelDone;
  logic [1:0] lives_left;
  logic [3:0] passes;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic       won;
    logic       lost;
    logic       roc;
    logic       done;
    logic [1:0] lives;
    logic [3:0] passes;
  } exp_t;

  exp_t sb_q[$];

  level_referee dut (
    .clk                  (clk),
    .reset                (reset),
    .menuScreen           (menuScreen),
    .start                (start),
    .collision            (collision),
    .obj_position_counter (obj_position_counter),
    .game_time            (game_time),
    .playerWon            (playerWon),
    .playerLost           (playerLost),
    .reset_obj_count      (reset_obj_count),
    .levelDone            (levelDone),
    .lives_left           (lives_left),
    .passes               (passes)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic won, input logic lost,
                            input logic roc, input logic done,
                            input logic [1:0] lives, input logic [3:0] np);
    exp_t e;
    e.tag = tag; e.won = won; e.lost = lost; e.roc = roc; e.done = done;
    e.lives = lives; e.passes = np;
    sb_q.push_back(e);
  endtask

  // Advance one clock and score every expectation queued for this edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, ".won"},    16'(playerWon),       16'(e.won));
      check({e.tag, ".lost"},   16'(playerLost),      16'(e.lost));
      check({e.tag, ".roc"},    16'(reset_obj_count), 16'(e.roc));
      check({e.tag, ".done"},   16'(levelDone),       16'(e.done));
      check({e.tag, ".lives"},  16'(lives_left),      16'(e.lives));
      check({e.tag, ".passes"}, 16'(passes),          16'(e.passes));
    end
  endtask

  initial begin
    reset = 1'b1; menuScreen = 1'b0; start = 1'b0; collision = 1'b0;
    obj_position_counter = '0; game_time = '0;
    tick();
    expect_out("reset", 0, 0, 0, 0, 2'd0, 4'd0);
    tick();

    reset = 1'b0;
    start = 1'b1;
    expect_out("start", 0, 0, 0, 0, 2'd3, 4'd0);
    tick();
    start = 1'b0;

    // Eight obstacle sweeps win the level.
    for (int p = 0; p < 8; p++) begin
      for (int pos = 0; pos <= 680; pos += 5) begin
        obj_position_counter = 10'(pos);
        if (pos == 675) expect_out("sweep_pre", 0, 0, 0, 0, 2'd3, 4'(p));
        if (pos == 680) expect_out("sweep_pass", (p == 7), 0, 0, (p == 7), 2'd3, 4'(p + 1));
        tick();
      end
    end
    obj_position_counter = '0;
    expect_out("won_hold1", 1, 0, 0, 0, 2'd3, 4'd8);
    tick();
    expect_out("won_hold2", 1, 0, 0, 0, 2'd3, 4'd8);
    tick();

    menuScreen = 1'b1;
    expect_out("menu_won", 0, 0, 0, 0, 2'd0, 4'd0);
    tick();
    menuScreen = 1'b0;
    start = 1'b1;
    expect_out("start2", 0, 0, 0, 0, 2'd3, 4'd0);
    tick();
    start = 1'b0;

    // Collision held through the whole cooldown; re-hit lands right after it.
    collision = 1'b1;
    expect_out("hit1", 0, 0, 1, 0, 2'd2, 4'd0);
    tick();
    for (int i = 1; i <= 30; i++) begin
      expect_out("cool1", 0, 0, 0, 0, 2'd2, 4'd0);
      tick();
    end
    expect_out("hit2", 0, 0, 1, 0, 2'd1, 4'd0);
    tick();
    collision = 1'b0;

    // Time limit ignored during cooldown, honoured once play resumes.
    game_time = 16'd3000;
    for (int i = 1; i <= 30; i++) begin
      expect_out("cool_time", 0, 0, 0, 0, 2'd1, 4'd0);
      tick();
    end
    expect_out("time_after_cool", 0, 1, 0, 0, 2'd1, 4'd0);
    tick();

    game_time = '0;
    start = 1'b1;
    expect_out("restart_lost", 0, 0, 0, 0, 2'd3, 4'd0);
    tick();
    start = 1'b0;

    game_time = 16'd2999;
    expect_out("time_below", 0, 0, 0, 0, 2'd3, 4'd0);
    tick();
    game_time = 16'd3000;
    expect_out("time_limit", 0, 1, 0, 0, 2'd3, 4'd0);
    tick();
    game_time = '0;
    start = 1'b1;
    expect_out("restart2", 0, 0, 0, 0, 2'd3, 4'd0);
    tick();
    start = 1'b0;

    obj_position_counter = 10'd685;
    for (int i = 0; i < 10; i++) begin
      expect_out("hold685", 0, 0, 0, 0, 2'd3, 4'd1);
      tick();
    end
    obj_position_counter = '0;
    expect_out("rearm", 0, 0, 0, 0, 2'd3, 4'd1);
    tick();

    obj_position_counter = 10'd680;
    collision = 1'b1;
    expect_out("hit_and_pass", 0, 0, 1, 0, 2'd2, 4'd1);
    tick();
    collision = 1'b0;
    obj_position_counter = '0;
    for (int i = 1; i <= 30; i++) begin
      if (i == 5) obj_position_counter = 10'd680;
      expect_out("cool_pass", 0, 0, 0, 0, 2'd2, 4'd1);
      tick();
    end
    collision = 1'b1;
    expect_out("hit_b", 0, 0, 1, 0, 2'd1, 4'd1);
    tick();
    collision = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      expect_out("cool_b", 0, 0, 0, 0, 2'd1, 4'd1);
      tick();
    end
    collision = 1'b1;
    expect_out("hit_last", 0, 1, 0, 0, 2'd0, 4'd1);
    tick();
    collision = 1'b0;
    expect_out("lost_hold", 0, 1, 0, 0, 2'd0, 4'd1);
    tick();

    start = 1'b1;
    expect_out("restart3", 0, 0, 0, 0, 2'd3, 4'd0);
    tick();
    start = 1'b0;
    collision = 1'b1;
    expect_out("hit_c", 0, 0, 1, 0, 2'd2, 4'd0);
    tick();
    collision = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_out("cool_c", 0, 0, 0, 0, 2'd2, 4'd0);
      tick();
    end
    reset = 1'b1;
    expect_out("reset_cool", 0, 0, 0, 0, 2'd0, 4'd0);
    tick();
    start = 1'b1;
    expect_out("reset_vs_start", 0, 0, 0, 0, 2'd0, 4'd0);
    tick();
    reset = 1'b0;
    start = 1'b0;
    expect_out("idle_after_reset", 0, 0, 0, 0, 2'd0, 4'd0);
    tick();
    start = 1'b1;
    expect_out("start_after_reset", 0, 0, 0, 0, 2'd3, 4'd0);
    tick();
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/level_referee.md
LEVEL_REFEREE -- requirements
Module: level_referee

Interface
REQ-001 Parameter WRAP_POS, default 680: object position at which one obstacle pass is counted.
REQ-002 Parameter WIN_PASSES, default 8: number of passes that wins the level.
REQ-003 Parameter LIVES, default 3: lives at start of play (range 1..3).
REQ-004 Parameter COOLDOWN_CYC, default 30: invulnerability cycles after a hit (1..255).
REQ-005 Parameter TIME_LIMIT, default 16'd3000: game_time value at which the level is lost.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 menuScreen  in  1  menu displayed; forces the referee idle.
REQ-009 start  in  1  single-cycle start request from the button debouncer.
REQ-010 collision  in  1  player/obstacle overlap from the pixel logic, level-sensitive.
REQ-011 obj_position_counter  in  10  obstacle position from the shape counter.
REQ-012 game_time  in  16  elapsed play cycles from the shape counter.
REQ-013 playerWon  out  1  high while in WON.
REQ-014 playerLost  out  1  high while in LOST.
REQ-015 reset_obj_count  out  1  one-cycle pulse restarting the obstacle after an accepted hit.
REQ-016 levelDone  out  1  one-cycle pulse on entry to WON.
REQ-017 lives_left  out  2  remaining lives.
REQ-018 passes  out  4  obstacle passes counted this level.

Function
REQ-019 FSM states SHALL be IDLE, PLAY, COOLDOWN, WON, LOST.
REQ-020 IDLE -> PLAY on start=1 with menuScreen=0; on entry lives_left=LIVES and passes=0.
REQ-021 menuScreen=1 in any state SHALL force IDLE next cycle, with top priority.
REQ-022 Pass event: obj_position_counter >= WRAP_POS while a registered "above" flag is 0; the flag tracks (counter >= WRAP_POS), so a position held at or beyond WRAP_POS counts exactly once.
REQ-023 Pass events SHALL increment passes only in PLAY; passes saturates at WIN_PASSES.
REQ-024 In PLAY, priority SHALL be menuScreen > collision > pass > timeout.
REQ-025 In PLAY, collision=1 with lives_left>1: decrement lives_left, pulse reset_obj_count next cycle, load the cooldown counter with COOLDOWN_CYC, and go to COOLDOWN.
REQ-026 In PLAY, collision=1 with lives_left==1: lives_left=0, go to LOST, no reset_obj_count pulse.
REQ-027 In PLAY, a pass making passes==WIN_PASSES SHALL go to WON, and levelDone SHALL pulse in the entry cycle.
REQ-028 In PLAY, game_time >= TIME_LIMIT SHALL go to LOST.
REQ-029 COOLDOWN: ignore collision and passes, decrement the counter each cycle, and return to PLAY when the counter reaches 0 (exactly COOLDOWN_CYC cycles in COOLDOWN).
REQ-030 WON and LOST SHALL hold until start=1 (go to PLAY, reinitialised) or menuScreen=1 (go to IDLE).
REQ-031 All outputs SHALL be registered; playerWon and playerLost SHALL assert in the first cycle the state is WON or LOST.
REQ-032 Game time SHALL NOT be checked in COOLDOWN; the check resumes in PLAY.

Reset
REQ-033 reset=1 SHALL give state=IDLE, lives_left=0, passes=0, cooldown counter=0, the above-flag cleared, and all pulse and status outputs 0 on the next edge, including mid-COOLDOWN.
REQ-034 reset SHALL have priority over menuScreen and start.

Structure
REQ-035 Shared package game_pkg holds the state enum type and the default constants WRAP_POS, WIN_PASSES, LIVES, COOLDOWN_CYC, and TIME_LIMIT.
REQ-036 One sub-module, pass_detector, SHALL contain the threshold compare, the above-flag, and the one-cycle pass pulse.

Verification
REQ-037 Start, then sweep counter 0->680 eight times with step 5 and no collision -> passes 1..8, WON, levelDone pulses once, playerWon stays high.
REQ-038 Collision in PLAY with LIVES=3 -> lives_left=2, one reset_obj_count pulse, 30 cycles COOLDOWN with collision held ignored, then PLAY.
REQ-039 Three separated collisions -> lives_left 2,1,0, LOST after the third, and no reset_obj_count on the third.
REQ-040 game_time driven to 3000 in PLAY -> LOST next cycle; the same value during COOLDOWN -> no LOST until PLAY resumes.
REQ-041 Counter held at 685 for 10 cycles -> passes increments once; collision and a pass in the same cycle -> the hit is taken and passes is unchanged.
REQ-042 reset mid-COOLDOWN and menuScreen in WON -> IDLE with all outputs 0; start in LOST -> PLAY with lives_left=3 and passes=0.
